// File: rtl/evo_pmux_pkg.sv
// rtl/evo_pmux_pkg.sv - shared types, CSR map constants and address helper for the port-mux sequencer
package evo_pmux_pkg;

  localparam int PMUX_AW = 12;

  typedef enum logic [2:0] {
    PMUX_PORT_D = 3'd0,
    PMUX_PORT_E = 3'd1,
    PMUX_PORT_F = 3'd2,
    PMUX_PORT_G = 3'd3,
    PMUX_PORT_Z = 3'd4
  } pmux_port_e;

  localparam logic [3:0] PMUX_OFF_CTL   = 4'd1;
  localparam logic [3:0] PMUX_OFF_STS   = 4'd2;
  localparam logic [3:0] PMUX_OFF_WRADR = 4'd3;
  localparam logic [3:0] PMUX_OFF_DIR   = 4'd4;
  localparam logic [3:0] PMUX_OFF_OUT   = 4'd5;
  localparam logic [3:0] PMUX_OFF_EN    = 4'd6;
  localparam logic [3:0] PMUX_OFF_IN    = 4'd7;

  localparam logic [PMUX_AW-1:0] PMUX_CSR_BASE    = 12'h910;
  localparam logic [PMUX_AW-1:0] PMUX_PORT_STRIDE = 12'h010;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR_ADR = 3'd1,
    ST_WR_DIR = 3'd2,
    ST_WR_OUT = 3'd3,
    ST_WR_EN  = 3'd4,
    ST_RD_STS = 3'd5,
    ST_RESP   = 3'd6
  } pmux_state_e;

  // Each port owns a 16-byte window above the bank base.
  function automatic logic [PMUX_AW-1:0] pmux_csr_addr(input logic [2:0] port,
                                                       input logic [3:0] off);
    return PMUX_CSR_BASE + (PMUX_PORT_STRIDE * {9'd0, port}) + {8'd0, off};
  endfunction

  function automatic logic pmux_port_legal(input logic [2:0] port);
    return port <= PMUX_PORT_Z;
  endfunction

endpackage

// File: rtl/evo_pmux_cfg_seq_if.sv
// rtl/evo_pmux_cfg_seq_if.sv - command, response and CSR bus bundle of the port-mux sequencer
interface evo_pmux_cfg_seq_if #(parameter int CSR_DW = 32);

  logic                             cmd_valid;
  logic                             cmd_ready;
  logic [2:0]                       cmd_port;
  logic [4:0]                       cmd_pin;
  logic                             cmd_dir;
  logic                             cmd_out;
  logic                             cmd_en;

  logic                             rsp_valid;
  logic                             rsp_ready;
  logic                             rsp_err;
  logic [7:0]                       rsp_polls;

  logic                             csr_req;
  logic                             csr_we;
  logic [evo_pmux_pkg::PMUX_AW-1:0] csr_addr;
  logic [CSR_DW-1:0]                csr_wdata;
  logic                             csr_ack;
  logic [CSR_DW-1:0]                csr_rdata;

  // Sequencer side: takes commands, returns responses, masters the CSR bus.
  modport master (
    input  cmd_valid, cmd_port, cmd_pin, cmd_dir, cmd_out, cmd_en,
    input  rsp_ready, csr_ack, csr_rdata,
    output cmd_ready, rsp_valid, rsp_err, rsp_polls,
    output csr_req, csr_we, csr_addr, csr_wdata
  );

  // Environment side: requester plus CSR bank.
  modport slave (
    output cmd_valid, cmd_port, cmd_pin, cmd_dir, cmd_out, cmd_en,
    output rsp_ready, csr_ack, csr_rdata,
    input  cmd_ready, rsp_valid, rsp_err, rsp_polls,
    input  csr_req, csr_we, csr_addr, csr_wdata
  );

endinterface

// File: rtl/evo_csr_master_if.sv
// rtl/evo_csr_master_if.sv - single-outstanding CSR access engine with registered bus outputs
module evo_csr_master_if
  import evo_pmux_pkg::*;
#(
  parameter int CSR_DW = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start_i,
  input  logic               we_i,
  input  logic [PMUX_AW-1:0] addr_i,
  input  logic [CSR_DW-1:0]  wdata_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [CSR_DW-1:0]  rdata_o,
  output logic               csr_req_o,
  output logic               csr_we_o,
  output logic [PMUX_AW-1:0] csr_addr_o,
  output logic [CSR_DW-1:0]  csr_wdata_o,
  input  logic               csr_ack_i,
  input  logic [CSR_DW-1:0]  csr_rdata_i
);

  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [PMUX_AW-1:0] addr_q, addr_d;
  logic [CSR_DW-1:0]  wdata_q, wdata_d;

  // Latch a new access on start; hold everything until ack, then drop req only.
  always_comb begin
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (req_q) begin
      if (csr_ack_i) begin
        req_d = 1'b0;
      end
    end else if (start_i) begin
      req_d   = 1'b1;
      we_d    = we_i;
      addr_d  = addr_i;
      wdata_d = wdata_i;
    end
  end

  // Bus output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // An ack seen while no request is outstanding is not a completion.
  assign done_o      = req_q & csr_ack_i;
  assign busy_o      = req_q;
  assign rdata_o     = csr_rdata_i;
  assign csr_req_o   = req_q;
  assign csr_we_o    = we_q;
  assign csr_addr_o  = addr_q;
  assign csr_wdata_o = wdata_q;

endmodule

// File: rtl/evo_pmux_cfg_seq.sv
// rtl/evo_pmux_cfg_seq.sv - expands one pin command into WRADR/DIR/OUT/EN writes then polls STS
module evo_pmux_cfg_seq
  import evo_pmux_pkg::*;
#(
  parameter int CSR_DW   = 32,
  parameter int POLL_MAX = 255,
  parameter int BUSY_BIT = 0
) (
  input logic                clk,
  input logic                reset_n,
  evo_pmux_cfg_seq_if.master bus
);

  localparam logic [15:0] POLL_LIMIT = 16'(POLL_MAX);

  pmux_state_e        state_q, state_d;
  logic [2:0]         port_q, port_d;
  logic [4:0]         pin_q, pin_d;
  logic               dir_q, dir_d;
  logic               out_q, out_d;
  logic               en_q, en_d;
  logic [15:0]        poll_q, poll_d;
  logic               err_q, err_d;
  logic [15:0]        poll_inc;

  logic               acc_start;
  logic               acc_we;
  logic [PMUX_AW-1:0] acc_addr;
  logic [CSR_DW-1:0]  acc_wdata;
  logic               acc_busy;
  logic               acc_done;
  logic [CSR_DW-1:0]  acc_rdata;
  logic               unused_rdata;

  assign poll_inc     = poll_q + 16'd1;
  assign unused_rdata = ^acc_rdata;

  // Next-state, command capture and access selection; a CSR state launches its
  // access whenever the engine is idle, which yields one dead cycle after each ack.
  always_comb begin
    state_d   = state_q;
    port_d    = port_q;
    pin_d     = pin_q;
    dir_d     = dir_q;
    out_d     = out_q;
    en_d      = en_q;
    poll_d    = poll_q;
    err_d     = err_q;
    acc_start = 1'b0;
    acc_we    = 1'b1;
    acc_addr  = pmux_csr_addr(port_q, PMUX_OFF_WRADR);
    acc_wdata = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          port_d = bus.cmd_port;
          pin_d  = bus.cmd_pin;
          dir_d  = bus.cmd_dir;
          out_d  = bus.cmd_out;
          en_d   = bus.cmd_en;
          poll_d = '0;
          if (pmux_port_legal(bus.cmd_port)) begin
            err_d   = 1'b0;
            state_d = ST_WR_ADR;
          end else begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_WR_ADR: begin
        acc_addr  = pmux_csr_addr(port_q, PMUX_OFF_WRADR);
        acc_wdata = CSR_DW'(pin_q);
        acc_start = !acc_busy;
        if (acc_done) state_d = ST_WR_DIR;
      end
      ST_WR_DIR: begin
        acc_addr  = pmux_csr_addr(port_q, PMUX_OFF_DIR);
        acc_wdata = CSR_DW'(dir_q);
        acc_start = !acc_busy;
        if (acc_done) state_d = ST_WR_OUT;
      end
      ST_WR_OUT: begin
        acc_addr  = pmux_csr_addr(port_q, PMUX_OFF_OUT);
        acc_wdata = CSR_DW'(out_q);
        acc_start = !acc_busy;
        if (acc_done) state_d = ST_WR_EN;
      end
      ST_WR_EN: begin
        acc_addr  = pmux_csr_addr(port_q, PMUX_OFF_EN);
        acc_wdata = CSR_DW'(en_q);
        acc_start = !acc_busy;
        if (acc_done) state_d = ST_RD_STS;
      end
      ST_RD_STS: begin
        acc_we    = 1'b0;
        acc_addr  = pmux_csr_addr(port_q, PMUX_OFF_STS);
        acc_start = !acc_busy;
        if (acc_done) begin
          poll_d = poll_inc;
          if (!acc_rdata[BUSY_BIT]) begin
            err_d   = 1'b0;
            state_d = ST_RESP;
          end else if (poll_inc >= POLL_LIMIT) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          poll_d  = '0;
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer state, captured command and poll bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      port_q  <= '0;
      pin_q   <= '0;
      dir_q   <= 1'b0;
      out_q   <= 1'b0;
      en_q    <= 1'b0;
      poll_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      pin_q   <= pin_d;
      dir_q   <= dir_d;
      out_q   <= out_d;
      en_q    <= en_d;
      poll_q  <= poll_d;
      err_q   <= err_d;
    end
  end

  evo_csr_master_if #(.CSR_DW(CSR_DW)) u_csr (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_i     (acc_start),
    .we_i        (acc_we),
    .addr_i      (acc_addr),
    .wdata_i     (acc_wdata),
    .busy_o      (acc_busy),
    .done_o      (acc_done),
    .rdata_o     (acc_rdata),
    .csr_req_o   (bus.csr_req),
    .csr_we_o    (bus.csr_we),
    .csr_addr_o  (bus.csr_addr),
    .csr_wdata_o (bus.csr_wdata),
    .csr_ack_i   (bus.csr_ack),
    .csr_rdata_i (bus.csr_rdata)
  );

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_err   = err_q;
  assign bus.rsp_polls = (poll_q > 16'd255) ? 8'hFF : poll_q[7:0];

endmodule

// File: doc/evo_pmux_cfg_seq.md
Name: evo_pmux_cfg_seq

Overview:
Configuration sequencer for the port-mux CSR bank (ports D, E, F, G, Z). It accepts one pin-configuration command at a time and expands it into the ordered CSR write sequence WRADR, DIR, OUT, EN. It then polls STS until the mux reports idle and returns a completion/error response. It sits between software-facing or autonomous requesters and the XB CSR bus, acting as a single CSR master.

Parameters:
CSR_DW, 32, CSR data width; command fields zero-extended into it
POLL_MAX, 255, maximum STS reads before timeout error; must be >= 1
BUSY_BIT, 0, bit index of the busy flag in the STS CSR

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command (high only in IDLE)
cmd_port  in  3  0=D, 1=E, 2=F, 3=G, 4=Z; 5-7 illegal
cmd_pin  in  5  pin index written to WRADR
cmd_dir  in  1  direction value
cmd_out  in  1  output value
cmd_en  in  1  mux enable value
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed
rsp_err  out  1  1 = illegal port or STS poll timeout
rsp_polls  out  8  number of STS reads performed, saturating at 255
csr_req  out  1  CSR access request
csr_we  out  1  1 = write, 0 = read
csr_addr  out  12  CSR address
csr_wdata  out  CSR_DW  write data
csr_ack  in  1  single-cycle access completion
csr_rdata  in  CSR_DW  read data, valid with csr_ack when csr_we=0

Behaviour:
- Reset (async assert, sync release): state=IDLE; cmd_ready=1; rsp_valid=0, rsp_err=0, rsp_polls=0; csr_req=0, csr_we=0, csr_addr=0, csr_wdata=0; poll counter=0.
- Address map: base = 12'h910 + (cmd_port << 4). Offsets: CTL+1, STS+2, WRADR+3, DIR+4, OUT+5, EN+6, IN+7. Examples: D WRADR=12'h913, Z EN=12'h956.
- Command capture: on cmd_valid & cmd_ready, all cmd_* fields are registered and cmd_ready drops the next cycle. Later changes to cmd_* inputs have no effect.
- States: IDLE -> WR_ADR -> WR_DIR -> WR_OUT -> WR_EN -> RD_STS -> RESP -> IDLE.
- Illegal port (>4): IDLE -> RESP directly, rsp_err=1, rsp_polls=0, no CSR traffic.
- Each CSR state:
  - csr_req, csr_we, csr_addr and csr_wdata are registered outputs, asserted the cycle after entry.
  - They are held stable until the cycle in which csr_ack=1.
  - csr_req deasserts the following cycle and the FSM advances; this gives one idle bus cycle between accesses.
  - There is no wait limit on csr_ack for writes.
- Write data, zero-extended to CSR_DW: WRADR=cmd_pin, DIR=cmd_dir, OUT=cmd_out, EN=cmd_en.
- RD_STS:
  - Each ack increments the poll counter.
  - If csr_rdata[BUSY_BIT]=0: go to RESP with rsp_err=0.
  - If busy and the counter has reached POLL_MAX: go to RESP with rsp_err=1.
  - Otherwise issue another read after one idle cycle.
- RESP:
  - rsp_valid=1, rsp_err and rsp_polls held stable until rsp_ready.
  - When rsp_valid & rsp_ready: rsp_valid=0 next cycle, return to IDLE, counter cleared.
  - cmd_ready reasserts in that same next cycle.
- cmd_valid is ignored outside IDLE. A stray csr_ack while csr_req=0 is ignored.
- Reset mid-sequence aborts immediately to reset values. The partially written CSR state is not rolled back.
- csr_ack in the same cycle as csr_req first rises is illegal; the bus guarantees ack latency of at least 1 cycle.

Decomposition:
- Shared package evo_pmux_pkg holds:
  - port enum: PMUX_PORT_D..PMUX_PORT_Z
  - CSR offset constants: CTL=1 .. IN=7
  - PMUX_CSR_BASE=12'h910 and PMUX_PORT_STRIDE=12'h10
  - FSM state enum
  - the address-computation function
- One natural sub-module, evo_csr_master_if: holds req/addr/we/wdata registers and the ack handshake. It exposes start/done/rdata to the FSM.

Test Plan:
- Port D, pin 3, dir=1, out=0, en=1; ack latency 1; STS busy=0 on first read -> four writes in order: (913,3), (914,1), (915,0), (916,1); one read of 912; rsp_err=0, rsp_polls=1.
- Port Z, pin 31; STS returns busy=1 three times then 0 -> reads of 952 four times; rsp_polls=4, rsp_err=0.
- POLL_MAX=4, STS permanently busy -> exactly 4 reads; rsp_err=1, rsp_polls=4.
- cmd_port=6 -> no csr_req for whole transaction; rsp_valid within 2 cycles; rsp_err=1, rsp_polls=0.
- Ack latency 5 cycles on DIR write, plus rsp_ready held low 10 cycles -> addr/wdata stable throughout the wait; rsp fields stable; cmd_ready stays low until the cycle after the handshake.
- Reset pulsed during WR_OUT -> outputs return to reset values asynchronously; new command afterwards restarts at WRADR.
